// File: rtl/open_riscv_cpu.sv
// RV32I core: 3-stage pipeline (IF, ID, EX/WB), Harvard memories, write-first register file.
// Optional build macro RETIRE_TRACE_EN adds a registered retire trace (dbg_retire_*).

module instruction_fetch #(
  parameter int          IMEM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          srst,
  input  logic                          redirect,
  input  logic [31:0]                   target,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  output logic [31:0]                   pc,
  output logic [31:0]                   inst
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] inst_mem [0:IMEM_DEPTH-1];
  logic [31:0] pc_reg, pc_next;

  assign pc_next = redirect ? target : pc_reg + 32'd4;

  always_ff @(posedge clk) begin
    if (srst) pc_reg <= RESET_PC;
    else      pc_reg <= pc_next;
  end

  // Program-load port; the core ties it off and benches preload the array directly.
  always_ff @(posedge clk) begin
    if (prog_we) inst_mem[prog_addr] <= prog_data;
  end

  assign pc   = pc_reg;
  assign inst = inst_mem[pc_reg[AW+1:2]];
endmodule

module register_file (
  input  logic            clk,
  input  logic            srst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [31:0]     wdata,
  input  logic [1:0][4:0] raddr,
  output logic [1:0][31:0] rdata
);
  logic [31:0] reg_mem [0:31];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 32; i++) reg_mem[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      reg_mem[waddr] <= wdata;
    end
  end

  // Write-first: a read of the register being written this cycle sees the new value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rdata[gi] = (we && waddr != 5'd0 && waddr == raddr[gi]) ? wdata : reg_mem[raddr[gi]];
  end
endmodule

module open_riscv_cpu #(
  parameter int          IMEM_DEPTH = 4096,
  parameter int          DMEM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst
`ifdef RETIRE_TRACE_EN
  ,
  output logic        dbg_retire_valid,
  output logic [31:0] dbg_retire_pc,
  output logic [31:0] dbg_retire_inst
`endif
);
  localparam int          DW         = $clog2(DMEM_DEPTH);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] if_pc, if_inst;

  instruction_fetch #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(RESET_PC)) instruction_fetch_inst (
    .clk(sys_clk), .srst(sys_rst), .redirect(redirect), .target(redirect_target),
    .prog_we(1'b0), .prog_addr('0), .prog_data('0), .pc(if_pc), .inst(if_inst)
  );

  // ---------------- ID ----------------
  logic [31:0]      ifid_inst_reg, ifid_pc_reg;
  logic [6:0]       id_opcode;
  logic [31:0]      id_imm;
  logic [1:0][4:0]  rf_raddr;
  logic [1:0][31:0] rf_rdata;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;

  assign id_opcode   = ifid_inst_reg[6:0];
  assign rf_raddr[0] = ifid_inst_reg[19:15];
  assign rf_raddr[1] = ifid_inst_reg[24:20];

  always_comb begin
    id_imm = {{20{ifid_inst_reg[31]}}, ifid_inst_reg[31:20]};
    case (id_opcode)
      OPC_STORE:          id_imm = {{20{ifid_inst_reg[31]}}, ifid_inst_reg[31:25], ifid_inst_reg[11:7]};
      OPC_BRANCH:         id_imm = {{19{ifid_inst_reg[31]}}, ifid_inst_reg[31], ifid_inst_reg[7],
                                    ifid_inst_reg[30:25], ifid_inst_reg[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: id_imm = {ifid_inst_reg[31:12], 12'd0};
      OPC_JAL:            id_imm = {{11{ifid_inst_reg[31]}}, ifid_inst_reg[31], ifid_inst_reg[19:12],
                                    ifid_inst_reg[20], ifid_inst_reg[30:21], 1'b0};
      default:            ;
    endcase
  end

  register_file register_file_inst (
    .clk(sys_clk), .srst(sys_rst), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr(rf_raddr), .rdata(rf_rdata)
  );

  // ---------------- pipeline registers ----------------
  logic [31:0] idex_pc_reg, idex_rs1_reg, idex_rs2_reg, idex_imm_reg;
  logic [6:0]  idex_opcode_reg;
  logic [4:0]  idex_rd_reg;
  logic [2:0]  idex_funct3_reg;
  logic        idex_alt_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || redirect) begin
      ifid_inst_reg   <= NOP;
      ifid_pc_reg     <= '0;
      idex_pc_reg     <= '0;
      idex_rs1_reg    <= '0;
      idex_rs2_reg    <= '0;
      idex_imm_reg    <= '0;
      idex_opcode_reg <= OPC_OP_IMM;
      idex_rd_reg     <= '0;
      idex_funct3_reg <= '0;
      idex_alt_reg    <= 1'b0;
    end else begin
      ifid_inst_reg   <= if_inst;
      ifid_pc_reg     <= if_pc;
      idex_pc_reg     <= ifid_pc_reg;
      idex_rs1_reg    <= rf_rdata[0];
      idex_rs2_reg    <= rf_rdata[1];
      idex_imm_reg    <= id_imm;
      idex_opcode_reg <= id_opcode;
      idex_rd_reg     <= ifid_inst_reg[11:7];
      idex_funct3_reg <= ifid_inst_reg[14:12];
      idex_alt_reg    <= ifid_inst_reg[30];
    end
  end

  // ---------------- EX/WB ----------------
  logic [31:0] op_b, alu_add, alu_res;
  logic        branch_taken;

  assign op_b    = (idex_opcode_reg == OPC_OP) ? idex_rs2_reg : idex_imm_reg;
  assign alu_add = idex_rs1_reg + op_b;

  always_comb begin
    alu_res = alu_add;
    case (idex_funct3_reg)
      3'b000: if (idex_opcode_reg == OPC_OP && idex_alt_reg) alu_res = idex_rs1_reg - op_b;
      3'b001: alu_res = idex_rs1_reg << op_b[4:0];
      3'b010: alu_res = {31'd0, $signed(idex_rs1_reg) < $signed(op_b)};
      3'b011: alu_res = {31'd0, idex_rs1_reg < op_b};
      3'b100: alu_res = idex_rs1_reg ^ op_b;
      3'b101: alu_res = idex_alt_reg ? 32'($signed(idex_rs1_reg) >>> op_b[4:0])
                                     : idex_rs1_reg >> op_b[4:0];
      3'b110: alu_res = idex_rs1_reg | op_b;
      default: alu_res = idex_rs1_reg & op_b;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (idex_funct3_reg)
      3'b000: branch_taken = idex_rs1_reg == idex_rs2_reg;
      3'b001: branch_taken = idex_rs1_reg != idex_rs2_reg;
      3'b100: branch_taken = $signed(idex_rs1_reg) <  $signed(idex_rs2_reg);
      3'b101: branch_taken = $signed(idex_rs1_reg) >= $signed(idex_rs2_reg);
      3'b110: branch_taken = idex_rs1_reg <  idex_rs2_reg;
      3'b111: branch_taken = idex_rs1_reg >= idex_rs2_reg;
      default: ;
    endcase
  end

  always_comb begin
    redirect        = 1'b0;
    redirect_target = idex_pc_reg + idex_imm_reg;
    if (idex_opcode_reg == OPC_JAL || (idex_opcode_reg == OPC_BRANCH && branch_taken)) begin
      redirect = 1'b1;
    end else if (idex_opcode_reg == OPC_JALR) begin
      redirect        = 1'b1;
      redirect_target = {alu_add[31:1], 1'b0};
    end
  end

  // Data memory: word array, byte lanes selected by the low address bits.
  logic [31:0]   dmem [0:DMEM_DEPTH-1];
  logic [DW-1:0] dmem_idx;
  logic [31:0]   load_word, load_res, store_data;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic          load_valid, store_en;
  logic [3:0]    store_be;

  assign dmem_idx  = alu_add[DW+1:2];
  assign load_word = dmem[dmem_idx];
  assign load_half = alu_add[1] ? load_word[31:16] : load_word[15:0];
  assign store_en  = (idex_opcode_reg == OPC_STORE) && !sys_rst;

  always_comb begin
    case (alu_add[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
  end

  always_comb begin
    load_valid = 1'b1;
    load_res   = load_word;
    case (idex_funct3_reg)
      3'b000: load_res = {{24{load_byte[7]}}, load_byte};
      3'b001: load_res = {{16{load_half[15]}}, load_half};
      3'b010: load_res = load_word;
      3'b100: load_res = {24'd0, load_byte};
      3'b101: load_res = {16'd0, load_half};
      default: load_valid = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign store_be[gi] = store_en &&
                          ((idex_funct3_reg == 3'b000 && alu_add[1:0] == LANE) ||
                           (idex_funct3_reg == 3'b001 && alu_add[1] == LANE[1]) ||
                           (idex_funct3_reg == 3'b010));
    assign store_data[gi*8 +: 8] = (idex_funct3_reg == 3'b000) ? idex_rs2_reg[7:0] :
                                   (idex_funct3_reg == 3'b001) ? idex_rs2_reg[(gi%2)*8 +: 8] :
                                                                 idex_rs2_reg[gi*8 +: 8];
  end

  always_ff @(posedge sys_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (store_be[b]) dmem[dmem_idx][b*8 +: 8] <= store_data[b*8 +: 8];
    end
  end

  assign rf_waddr = idex_rd_reg;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    case (idex_opcode_reg)
      OPC_LUI:            begin rf_we = 1'b1; rf_wdata = idex_imm_reg; end
      OPC_AUIPC:          begin rf_we = 1'b1; rf_wdata = idex_pc_reg + idex_imm_reg; end
      OPC_JAL, OPC_JALR:  begin rf_we = 1'b1; rf_wdata = idex_pc_reg + 32'd4; end
      OPC_OP, OPC_OP_IMM: rf_we = 1'b1;
      OPC_LOAD:           begin rf_we = load_valid; rf_wdata = load_res; end
      default:            ;
    endcase
  end

`ifdef RETIRE_TRACE_EN
  logic        ifid_valid_reg, idex_valid_reg, retire_valid_reg;
  logic [31:0] idex_inst_reg, retire_pc_reg, retire_inst_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || redirect) begin
      ifid_valid_reg <= 1'b0;
      idex_valid_reg <= 1'b0;
      idex_inst_reg  <= NOP;
    end else begin
      ifid_valid_reg <= 1'b1;
      idex_valid_reg <= ifid_valid_reg;
      idex_inst_reg  <= ifid_inst_reg;
    end
  end

  // The redirecting instruction itself still retires; only the squashed slots are hidden.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      retire_valid_reg <= 1'b0;
      retire_pc_reg    <= '0;
      retire_inst_reg  <= '0;
    end else begin
      retire_valid_reg <= idex_valid_reg;
      retire_pc_reg    <= idex_valid_reg ? idex_pc_reg : '0;
      retire_inst_reg  <= idex_valid_reg ? idex_inst_reg : '0;
    end
  end

  assign dbg_retire_valid = retire_valid_reg;
  assign dbg_retire_pc    = retire_pc_reg;
  assign dbg_retire_inst  = retire_inst_reg;
`endif
endmodule

// File: tb/tb_open_riscv_cpu.sv
// Bench for open_riscv_cpu: runs small programs and scoreboards the final register values.
module tb_open_riscv_cpu;
  localparam int          IMEM_DEPTH = 4096;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

`ifdef RETIRE_TRACE_EN
  logic        dbg_retire_valid;
  logic [31:0] dbg_retire_pc, dbg_retire_inst;
`endif

  open_riscv_cpu #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(4096), .RESET_PC(32'h0)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst)
`ifdef RETIRE_TRACE_EN
    ,
    .dbg_retire_valid(dbg_retire_valid),
    .dbg_retire_pc(dbg_retire_pc),
    .dbg_retire_inst(dbg_retire_inst)
`endif
  );

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] prog[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd,
                                        input logic [6:0] op);
    logic [31:0] v, a, f, d;
    v = imm; a = rs1; f = f3; d = rd;
    return {v[11:0], a[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                        input int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[11:5], b[4:0], a[4:0], f[2:0], v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, b, a, f;
    v = imm; b = rs2; a = rs1; f = f3;
    return {v[12], v[10:5], b[4:0], a[4:0], f[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v, d;
    v = imm20; d = rd;
    return {v[19:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'b1101111};
  endfunction

  task automatic expect_reg(input string tag, input int idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.idx = idx; e.val = val;
    sb_q.push_back(e);
  endtask

  // Holds reset for two edges while the program is loaded, then releases at a falling edge.
  task automatic load_and_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    for (int i = 0; i < IMEM_DEPTH; i++) dut.instruction_fetch_inst.inst_mem[i] = NOP;
    for (int i = 0; i < prog.size(); i++) dut.instruction_fetch_inst.inst_mem[i] = prog[i];
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic drain_scoreboard();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, dut.register_file_inst.reg_mem[e.idx], e.val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Program A: reset state, x0 immutability, back-to-back dependencies, ALU ops.
    prog = '{};
    prog.push_back(enc_i(5, 0, 0, 0, OPC_OP_IMM));        // addi x0,x0,5
    prog.push_back(enc_i(7, 0, 0, 1, OPC_OP_IMM));        // addi x1,x0,7
    prog.push_back(enc_i(3, 1, 0, 2, OPC_OP_IMM));        // addi x2,x1,3
    prog.push_back(enc_r(0, 1, 2, 0, 3));                 // add  x3,x2,x1
    prog.push_back(enc_r(32, 2, 1, 0, 8));                // sub  x8,x1,x2
    prog.push_back(enc_i(-16, 0, 0, 9, OPC_OP_IMM));      // addi x9,x0,-16
    prog.push_back(enc_i(32'h402, 9, 5, 10, OPC_OP_IMM)); // srai x10,x9,2
    prog.push_back(enc_i(28, 9, 5, 11, OPC_OP_IMM));      // srli x11,x9,28
    prog.push_back(enc_r(0, 1, 9, 2, 12));                // slt  x12,x9,x1
    prog.push_back(enc_r(0, 1, 9, 3, 13));                // sltu x13,x9,x1
    prog.push_back(enc_i(-1, 1, 4, 14, OPC_OP_IMM));      // xori x14,x1,-1
    prog.push_back(enc_r(0, 2, 1, 1, 15));                // sll  x15,x1,x2
    prog.push_back(enc_i(32'h7F, 9, 7, 16, OPC_OP_IMM));  // andi x16,x9,0x7f
    prog.push_back(enc_i(32'h100, 1, 6, 17, OPC_OP_IMM)); // ori  x17,x1,0x100
    prog.push_back(enc_j(0, 0));                          // jal  x0,0
    load_and_reset();
    for (int r = 0; r < 32; r++) check_eq($sformatf("reset_x%0d", r), dut.register_file_inst.reg_mem[r], 32'h0);
    repeat (5) @(posedge sys_clk);
    #1 check_eq("x3_not_early", dut.register_file_inst.reg_mem[3], 32'h0);
    @(posedge sys_clk);
    #1 check_eq("x3_no_stall", dut.register_file_inst.reg_mem[3], 32'd17);
    expect_reg("A_x0", 0, 32'h0);
    expect_reg("A_x1", 1, 32'd7);
    expect_reg("A_x2", 2, 32'd10);
    expect_reg("A_x3", 3, 32'd17);
    expect_reg("A_sub", 8, 32'hFFFF_FFFD);
    expect_reg("A_srai", 10, 32'hFFFF_FFFC);
    expect_reg("A_srli", 11, 32'h0000_000F);
    expect_reg("A_slt", 12, 32'd1);
    expect_reg("A_sltu", 13, 32'd0);
    expect_reg("A_xori", 14, 32'hFFFF_FFF8);
    expect_reg("A_sll", 15, 32'h0000_1C00);
    expect_reg("A_andi", 16, 32'h0000_0070);
    expect_reg("A_ori", 17, 32'h0000_0107);
    repeat (30) @(posedge sys_clk);
    @(negedge sys_clk);
    drain_scoreboard();

    // Program B: branches, flushes, JAL/JALR link values.
    prog = '{};
    prog.push_back(enc_b(8, 0, 0, 0));                    // 00 beq  x0,x0,+8
    prog.push_back(enc_i(1, 0, 0, 5, OPC_OP_IMM));        // 04 addi x5,x0,1   (flushed)
    prog.push_back(enc_i(2, 0, 0, 6, OPC_OP_IMM));        // 08 addi x6,x0,2
    prog.push_back(NOP);                                  // 0c
    prog.push_back(enc_j(8, 1));                          // 10 jal  x1,+8
    prog.push_back(enc_i(9, 0, 0, 7, OPC_OP_IMM));        // 14 addi x7,x0,9   (flushed)
    prog.push_back(enc_b(8, 0, 6, 1));                    // 18 bne  x6,x0,+8
    prog.push_back(enc_i(10, 0, 0, 7, OPC_OP_IMM));       // 1c (flushed)
    prog.push_back(enc_b(8, 6, 0, 4));                    // 20 blt  x0,x6,+8
    prog.push_back(enc_i(1, 0, 0, 18, OPC_OP_IMM));       // 24 (flushed)
    prog.push_back(enc_b(8, 6, 0, 7));                    // 28 bgeu x0,x6,+8  (not taken)
    prog.push_back(enc_i(3, 0, 0, 19, OPC_OP_IMM));       // 2c addi x19,x0,3
    prog.push_back(enc_i(-1, 0, 0, 20, OPC_OP_IMM));      // 30 addi x20,x0,-1
    prog.push_back(enc_b(8, 20, 6, 6));                   // 34 bltu x6,x20,+8
    prog.push_back(enc_i(1, 0, 0, 21, OPC_OP_IMM));       // 38 (flushed)
    prog.push_back(enc_b(8, 6, 20, 5));                   // 3c bge  x20,x6,+8 (not taken)
    prog.push_back(enc_i(4, 0, 0, 22, OPC_OP_IMM));       // 40 addi x22,x0,4
    prog.push_back(enc_i(32'h51, 0, 0, 23, OPC_JALR));    // 44 jalr x23,x0,0x51
    prog.push_back(enc_i(1, 0, 0, 24, OPC_OP_IMM));       // 48 (flushed)
    prog.push_back(enc_i(2, 0, 0, 24, OPC_OP_IMM));       // 4c (skipped)
    prog.push_back(enc_i(5, 0, 0, 25, OPC_OP_IMM));       // 50 addi x25,x0,5
    prog.push_back(enc_j(0, 0));                          // 54 jal  x0,0
    load_and_reset();
    expect_reg("B_beq_flush", 5, 32'd0);
    expect_reg("B_beq_target", 6, 32'd2);
    expect_reg("B_jal_link", 1, 32'h14);
    expect_reg("B_jal_flush", 7, 32'd0);
    expect_reg("B_blt_flush", 18, 32'd0);
    expect_reg("B_bgeu_fall", 19, 32'd3);
    expect_reg("B_minus1", 20, 32'hFFFF_FFFF);
    expect_reg("B_bltu_flush", 21, 32'd0);
    expect_reg("B_bge_fall", 22, 32'd4);
    expect_reg("B_jalr_link", 23, 32'h48);
    expect_reg("B_jalr_skip", 24, 32'd0);
    expect_reg("B_jalr_target", 25, 32'd5);
    repeat (60) @(posedge sys_clk);
    @(negedge sys_clk);
    drain_scoreboard();

    // Program C: loads/stores with lane selection, misalignment, AUIPC/LUI.
    prog = '{};
    prog.push_back(enc_u(32'h80000, 1, OPC_LUI));         // 00 lui  x1,0x80000
    prog.push_back(enc_i(32'hFF, 1, 0, 1, OPC_OP_IMM));   // 04 addi x1,x1,0xff
    prog.push_back(enc_i(32'h100, 0, 0, 2, OPC_OP_IMM));  // 08 addi x2,x0,0x100
    prog.push_back(enc_s(0, 1, 2, 2));                    // 0c sw   x1,0(x2)
    prog.push_back(enc_i(0, 2, 0, 3, OPC_LOAD));          // 10 lb   x3,0(x2)
    prog.push_back(enc_i(0, 2, 4, 4, OPC_LOAD));          // 14 lbu  x4,0(x2)
    prog.push_back(enc_i(2, 2, 1, 5, OPC_LOAD));          // 18 lh   x5,2(x2)
    prog.push_back(enc_i(2, 2, 5, 6, OPC_LOAD));          // 1c lhu  x6,2(x2)
    prog.push_back(enc_u(1, 7, OPC_AUIPC));               // 20 auipc x7,1
    prog.push_back(enc_u(32'hFFFFF, 8, OPC_LUI));         // 24 lui  x8,0xfffff
    prog.push_back(enc_s(4, 0, 2, 2));                    // 28 sw   x0,4(x2)
    prog.push_back(enc_i(32'h5A, 0, 0, 9, OPC_OP_IMM));   // 2c addi x9,x0,0x5a
    prog.push_back(enc_s(5, 9, 2, 0));                    // 30 sb   x9,5(x2)
    prog.push_back(enc_s(6, 9, 2, 1));                    // 34 sh   x9,6(x2)
    prog.push_back(enc_i(4, 2, 2, 10, OPC_LOAD));         // 38 lw   x10,4(x2)
    prog.push_back(enc_i(1, 2, 1, 11, OPC_LOAD));         // 3c lh   x11,1(x2)
    prog.push_back(enc_i(3, 2, 2, 12, OPC_LOAD));         // 40 lw   x12,3(x2)
    prog.push_back(enc_i(3, 2, 0, 13, OPC_LOAD));         // 44 lb   x13,3(x2)
    prog.push_back(enc_i(3, 2, 5, 14, OPC_LOAD));         // 48 lhu  x14,3(x2)
    prog.push_back(enc_j(0, 0));                          // 4c jal  x0,0
    load_and_reset();
    expect_reg("C_lb", 3, 32'hFFFF_FFFF);
    expect_reg("C_lbu", 4, 32'h0000_00FF);
    expect_reg("C_lh", 5, 32'hFFFF_8000);
    expect_reg("C_lhu", 6, 32'h0000_8000);
    expect_reg("C_auipc", 7, 32'h0000_1020);
    expect_reg("C_lui", 8, 32'hFFFF_F000);
    expect_reg("C_sb_sh_lw", 10, 32'h005A_5A00);
    expect_reg("C_lh_misal", 11, 32'h0000_00FF);
    expect_reg("C_lw_misal", 12, 32'h8000_00FF);
    expect_reg("C_lb_lane3", 13, 32'hFFFF_FF80);
    expect_reg("C_lhu_misal", 14, 32'h0000_8000);
    repeat (50) @(posedge sys_clk);
    @(negedge sys_clk);
    drain_scoreboard();

    // Reset asserted mid-run clears the register file on the next edge.
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
    for (int r = 1; r < 32; r++) check_eq($sformatf("midrst_x%0d", r), dut.register_file_inst.reg_mem[r], 32'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(posedge sys_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
